// File: rtl/urm_trigger.sv
`default_nettype none
// ============================================================================
//  Module   : urm_trigger
//  Purpose  : Rising-edge trigger generator for HC-SR04 class ultrasonic
//             sensors: fixed-width TRIG pulse followed by a re-trigger holdoff.
//  Revision : 1.0
// ============================================================================
module urm_trigger #(
   parameter int PULSE_CYCLES   = 500,
   parameter int HOLDOFF_CYCLES = 1000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic TriggerIn,
   output logic TriggerOut,
   output logic Busy
);

   localparam int c_MAX_CYCLES = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
   localparam int CNT_W        = $clog2(c_MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] c_PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_HOLD_LOAD  = CNT_W'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PULSE   = 2'd1,
      S_HOLDOFF = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic             r_trig_out;
   logic             r_busy;
   logic             w_rise;

   // s3 is cleared by reset, so an input still high after release is a new edge
   assign w_rise = r_s2 & ~r_s3;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_trig_out <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_s1 <= TriggerIn;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state    <= S_PULSE;
                  r_cnt      <= c_PULSE_LOAD;
                  r_trig_out <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_PULSE: begin
               if (r_cnt == '0) begin
                  r_trig_out <= 1'b0;
                  if (HOLDOFF_CYCLES == 0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_HOLDOFF;
                     r_cnt   <= c_HOLD_LOAD;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_HOLDOFF: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_cnt      <= '0;
               r_trig_out <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign TriggerOut = r_trig_out;
   assign Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_urm_trigger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_urm_trigger
//  Purpose  : Directed, table-driven self-checking bench for urm_trigger.
//  Revision : 1.0
// ============================================================================
module tb_urm_trigger;

   localparam int PULSE = 500;
   localparam int HOLD  = 1000;

   logic Clock     = 1'b0;
   logic Reset     = 1'b0;
   logic TriggerIn = 1'b0;
   logic TriggerOut;
   logic Busy;

   int n_checks = 0;
   int n_fail   = 0;

   urm_trigger #(
      .PULSE_CYCLES  (PULSE),
      .HOLDOFF_CYCLES(HOLD)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .TriggerIn (TriggerIn),
      .TriggerOut(TriggerOut),
      .Busy      (Busy)
   );

   always #10 Clock = ~Clock;

   typedef struct {
      int in_len;
      int extra;
      int period;
      int window;
      int exp_pulses;
      int exp_high;
      int exp_busy;
      int exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with Reset released
   task automatic do_reset();
      Reset = 1'b1;
      #1;
      check("reset_out", int'(TriggerOut), 0);
      check("reset_busy", int'(Busy), 0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   // Sample index t is the posedge at which TriggerIn value for t is captured.
   task automatic run(input int in_len, input int extra, input int period, input int window,
                      output int pulses, output int high, output int busy, output int lat);
      logic prev;
      pulses = 0; high = 0; busy = 0; lat = -1; prev = 1'b0;
      for (int t = 0; t < window; t++) begin
         TriggerIn = (t < in_len) || (t == extra) || (period != 0 && (t % period) == 0);
         @(posedge Clock);
         #1;
         if (TriggerOut === 1'b1) begin
            high++;
            if (!prev) begin
               pulses++;
               if (lat < 0) lat = t;
            end
         end
         if (Busy === 1'b1) busy++;
         prev = (TriggerOut === 1'b1);
         @(negedge Clock);
      end
   endtask

   initial begin
      int p, h, b, l;

      //            in_len extra period window pulses high  busy  lat
      vecs[0] = '{1,    -1,    0,     2000,  1,     500,  1500, 2};
      vecs[1] = '{1,    202,   0,     2000,  1,     500,  1500, 2};
      vecs[2] = '{1,    1302,  0,     2000,  1,     500,  1500, 2};
      vecs[3] = '{1,    1500,  0,     3500,  1,     500,  1500, 2};
      vecs[4] = '{1,    1501,  0,     3500,  2,     1000, 3000, 2};
      vecs[5] = '{3,    -1,    0,     2000,  1,     500,  1500, 2};
      vecs[6] = '{5000, -1,    0,     5200,  1,     500,  1500, 2};
      vecs[7] = '{1,    -1,    5001,  15003, 3,     1500, 4500, 2};

      @(negedge Clock);
      do_reset();
      run(0, -1, 0, 10000, p, h, b, l);
      check("idle_pulses", p, 0);
      check("idle_high", h, 0);
      check("idle_busy", b, 0);

      for (int i = 0; i < 8; i++) begin
         do_reset();
         run(vecs[i].in_len, vecs[i].extra, vecs[i].period, vecs[i].window, p, h, b, l);
         TriggerIn = 1'b0;
         check($sformatf("v%0d_pulses", i), p, vecs[i].exp_pulses);
         check($sformatf("v%0d_high", i), h, vecs[i].exp_high);
         check($sformatf("v%0d_busy", i), b, vecs[i].exp_busy);
         check($sformatf("v%0d_latency", i), l, vecs[i].exp_lat);
      end

      // Reset 250 cycles into a pulse, then a fresh edge
      do_reset();
      run(1, -1, 0, 252, p, h, b, l);
      check("mid_high_before_reset", h, 250);
      #3 Reset = 1'b1;
      #1;
      check("mid_reset_out", int'(TriggerOut), 0);
      check("mid_reset_busy", int'(Busy), 0);
      @(negedge Clock);
      Reset = 1'b0;
      run(1, -1, 0, 2000, p, h, b, l);
      check("after_mid_pulses", p, 1);
      check("after_mid_high", h, 500);
      check("after_mid_lat", l, 2);

      // TriggerIn held high across reset counts as a new edge after release
      do_reset();
      run(3000, -1, 0, 1000, p, h, b, l);
      check("held_pre_pulses", p, 1);
      #3 Reset = 1'b1;
      #1;
      check("held_reset_out", int'(TriggerOut), 0);
      @(negedge Clock);
      Reset = 1'b0;
      run(3000, -1, 0, 2500, p, h, b, l);
      TriggerIn = 1'b0;
      check("held_post_pulses", p, 1);
      check("held_post_high", h, 500);
      check("held_post_lat", l, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
